// File: rtl/lab3_mem_refill_arbiter.sv
// Two-to-one refill arbiter: icache/dcache cache2mem streams onto one 16B memory port,
// responses steered back by an in-order FIFO of source ids; zero added latency.
module lab3_mem_refill_arbiter #(
  parameter int p_num_inflight = 4,
  parameter int p_req_nbits    = 175,
  parameter int p_resp_nbits   = 145
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  cache0_reqstream_msg,
  input  logic                    cache0_reqstream_val,
  output logic                    cache0_reqstream_rdy,
  output logic [p_resp_nbits-1:0] cache0_respstream_msg,
  output logic                    cache0_respstream_val,
  input  logic                    cache0_respstream_rdy,

  input  logic [p_req_nbits-1:0]  cache1_reqstream_msg,
  input  logic                    cache1_reqstream_val,
  output logic                    cache1_reqstream_rdy,
  output logic [p_resp_nbits-1:0] cache1_respstream_msg,
  output logic                    cache1_respstream_val,
  input  logic                    cache1_respstream_rdy,

  output logic [p_req_nbits-1:0]  mem_reqstream_msg,
  output logic                    mem_reqstream_val,
  input  logic                    mem_reqstream_rdy,
  input  logic [p_resp_nbits-1:0] mem_respstream_msg,
  input  logic                    mem_respstream_val,
  output logic                    mem_respstream_rdy
);

  localparam int PW = (p_num_inflight > 1) ? $clog2(p_num_inflight) : 1;
  localparam int CW = $clog2(p_num_inflight + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_num_inflight);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_num_inflight - 1);

  logic          prio_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic          id_mem [p_num_inflight];

  logic full;
  logic empty;
  logic grant0;
  logic grant1;
  logic both_val;
  logic head;
  logic req_fire;
  logic resp_fire;

  // Explicit wrap keeps non-power-of-2 depths from walking off the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (count_reg == FULL_CNT);
    empty    = (count_reg == '0);
    both_val = cache0_reqstream_val & cache1_reqstream_val;
    grant1   = cache1_reqstream_val & (~cache0_reqstream_val | prio_reg);
    grant0   = cache0_reqstream_val & ~grant1;
    head     = id_mem[rptr_reg];
  end

  // Outputs are also gated by reset so nothing can fire while state is being cleared.
  always_comb begin
    mem_reqstream_val     = ~reset & (cache0_reqstream_val | cache1_reqstream_val) & ~full;
    mem_reqstream_msg     = grant1 ? cache1_reqstream_msg : cache0_reqstream_msg;
    cache0_reqstream_rdy  = ~reset & grant0 & mem_reqstream_rdy & ~full;
    cache1_reqstream_rdy  = ~reset & grant1 & mem_reqstream_rdy & ~full;

    cache0_respstream_val = ~reset & mem_respstream_val & ~empty & ~head;
    cache1_respstream_val = ~reset & mem_respstream_val & ~empty & head;
    cache0_respstream_msg = mem_respstream_msg;
    cache1_respstream_msg = mem_respstream_msg;
    mem_respstream_rdy    = ~reset & ~empty &
                            (head ? cache1_respstream_rdy : cache0_respstream_rdy);

    req_fire  = mem_reqstream_val & mem_reqstream_rdy;
    resp_fire = mem_respstream_val & mem_respstream_rdy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg  <= 1'b0;
      count_reg <= '0;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
    end else begin
      if (req_fire) begin
        wptr_reg <= ptr_inc(wptr_reg);
        if (both_val) prio_reg <= ~grant1;
      end
      if (resp_fire) rptr_reg <= ptr_inc(rptr_reg);
      case ({req_fire, resp_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Id storage needs no reset: entries are only read while count_reg is nonzero.
  always_ff @(posedge clk) begin
    if (!reset && req_fire) id_mem[wptr_reg] <= grant1;
  end

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
// Directed bench for lab3_mem_refill_arbiter: stimulus queues expected transfers and
// per-cycle val/rdy levels; a negedge monitor pops and compares them.
module tb_lab3_mem_refill_arbiter;
  localparam int RQ = 175;
  localparam int RS = 145;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RQ-1:0] c0_req_msg, c1_req_msg, mem_req_msg;
  logic          c0_req_val, c0_req_rdy, c1_req_val, c1_req_rdy;
  logic [RS-1:0] c0_resp_msg, c1_resp_msg, mem_resp_msg;
  logic          c0_resp_val, c0_resp_rdy, c1_resp_val, c1_resp_rdy;
  logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;

  always #5 clk = ~clk;

  lab3_mem_refill_arbiter #(.p_num_inflight(4)) dut (
    .clk(clk), .reset(reset),
    .cache0_reqstream_msg(c0_req_msg), .cache0_reqstream_val(c0_req_val),
    .cache0_reqstream_rdy(c0_req_rdy), .cache0_respstream_msg(c0_resp_msg),
    .cache0_respstream_val(c0_resp_val), .cache0_respstream_rdy(c0_resp_rdy),
    .cache1_reqstream_msg(c1_req_msg), .cache1_reqstream_val(c1_req_val),
    .cache1_reqstream_rdy(c1_req_rdy), .cache1_respstream_msg(c1_resp_msg),
    .cache1_respstream_val(c1_resp_val), .cache1_respstream_rdy(c1_resp_rdy),
    .mem_reqstream_msg(mem_req_msg), .mem_reqstream_val(mem_req_val),
    .mem_reqstream_rdy(mem_req_rdy), .mem_respstream_msg(mem_resp_msg),
    .mem_respstream_val(mem_resp_val), .mem_respstream_rdy(mem_resp_rdy)
  );

  logic [5:0]    lvl_q [$];
  logic [RQ-1:0] mem_q [$];
  logic [RS-1:0] r0_q  [$];
  logic [RS-1:0] r1_q  [$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          done  = 1'b0;

  // Request: type | opaque | addr | len | data
  function automatic logic [RQ-1:0] mreq(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] a);
    return {t, op, a, 4'd0, a, ~a, a ^ 32'h5a5a5a5a, {op, op, op, op}};
  endfunction

  // Response: type | opaque | test | len | data
  function automatic logic [RS-1:0] mresp(input logic [2:0] t, input logic [7:0] op);
    return {t, op, 2'b00, 4'd0, {16{op}}};
  endfunction

  // Level vector order: {mem_req_val, c0_req_rdy, c1_req_rdy, mem_resp_rdy, c0_resp_val, c1_resp_val}
  task automatic cyc(input logic [5:0] e);
    lvl_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic both_issue(input logic [7:0] op, input logic exp_grant1);
    c0_req_val = 1'b1; c0_req_msg = mreq(3'd0, op, 32'h2000 + {24'd0, op});
    c1_req_val = 1'b1; c1_req_msg = mreq(3'd1, op + 8'h80, 32'h3000 + {24'd0, op});
    if (exp_grant1) begin mem_q.push_back(c1_req_msg); cyc(6'b101000); end
    else            begin mem_q.push_back(c0_req_msg); cyc(6'b110000); end
  endtask

  task automatic resp_to(input logic [7:0] op, input logic exp_head1);
    mem_resp_val = 1'b1; mem_resp_msg = mresp(3'd0, op);
    if (exp_head1) begin r1_q.push_back(mem_resp_msg); cyc(6'b000101); end
    else           begin r0_q.push_back(mem_resp_msg); cyc(6'b000110); end
  endtask

  task automatic idle_inputs();
    c0_req_val = 1'b0; c1_req_val = 1'b0; mem_resp_val = 1'b0;
  endtask

  initial begin
    c0_req_msg = '0; c1_req_msg = '0; mem_resp_msg = '0;
    idle_inputs();
    mem_req_rdy = 1'b1; c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    @(posedge clk); #1;

    // Reset with live inputs: all outputs held low, then low on the cycle after.
    c0_req_val = 1'b1; c1_req_val = 1'b1; mem_resp_val = 1'b1;
    cyc(6'b000000);
    reset = 1'b0; idle_inputs();
    cyc(6'b000000);

    // Single cache0 read, first with memory stalling.
    c0_req_val = 1'b1; c0_req_msg = mreq(3'd0, 8'h00, 32'h1000);
    mem_req_rdy = 1'b0;
    cyc(6'b100000);
    mem_req_rdy = 1'b1;
    mem_q.push_back(c0_req_msg);
    cyc(6'b110000);
    c0_req_val = 1'b0;
    resp_to(8'h00, 1'b0);
    idle_inputs();

    // Round-robin from prio 0 fills the FIFO; the 5th request waits for a slot.
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) both_issue(8'h01 + 8'(i), i[0]);
    c1_req_val = 1'b0;
    c0_req_val = 1'b1; c0_req_msg = mreq(3'd0, 8'h05, 32'h4000);
    cyc(6'b000000);
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    resp_to(8'h01, 1'b0);
    mem_resp_val = 1'b0;
    mem_q.push_back(c0_req_msg);
    cyc(6'b110100);
    c0_req_val = 1'b0;
    for (int j = 0; j < 4; j++) resp_to(8'h20 + 8'(j), ~j[0]);
    idle_inputs();

    // prio -> 1, then cache1 alone three times keeps prio at 1.
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    both_issue(8'h30, 1'b0);
    c0_req_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c1_req_val = 1'b1; c1_req_msg = mreq(3'd0, 8'h32 + 8'(k), 32'h5000);
      mem_q.push_back(c1_req_msg);
      cyc(6'b101000);
    end
    c1_req_val = 1'b0;
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    resp_to(8'h40, 1'b0);
    for (int j = 1; j < 4; j++) resp_to(8'h40 + 8'(j), 1'b1);
    mem_resp_val = 1'b0;
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    both_issue(8'h38, 1'b1);
    idle_inputs();
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    resp_to(8'h48, 1'b1);
    idle_inputs();

    // cache1 write then cache0 read; cache1 back-pressures its response.
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    c1_req_val = 1'b1; c1_req_msg = mreq(3'd1, 8'h51, 32'h6000);
    mem_q.push_back(c1_req_msg);
    cyc(6'b101000);
    c1_req_val = 1'b0;
    c0_req_val = 1'b1; c0_req_msg = mreq(3'd0, 8'h52, 32'h7000);
    mem_q.push_back(c0_req_msg);
    cyc(6'b110000);
    c0_req_val = 1'b0;
    c0_resp_rdy = 1'b1;
    mem_resp_val = 1'b1; mem_resp_msg = mresp(3'd1, 8'h51);
    for (int k = 0; k < 3; k++) cyc(6'b000001);
    c1_resp_rdy = 1'b1;
    r1_q.push_back(mem_resp_msg);
    cyc(6'b000101);
    resp_to(8'h52, 1'b0);
    idle_inputs();

    // Reset with two outstanding ids and prio 1; afterwards prio 0 and count 0.
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    both_issue(8'h60, 1'b0);
    c0_req_val = 1'b0;
    c1_req_val = 1'b1; c1_req_msg = mreq(3'd0, 8'h62, 32'h8000);
    mem_q.push_back(c1_req_msg);
    cyc(6'b101000);
    reset = 1'b1; mem_resp_val = 1'b1;
    cyc(6'b000000);
    reset = 1'b0; idle_inputs();
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    cyc(6'b000000);
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) both_issue(8'h70 + 8'(i), i[0]);
    c1_req_val = 1'b0;
    c0_req_val = 1'b1; c0_req_msg = mreq(3'd0, 8'h7f, 32'h9000);
    cyc(6'b000000);
    c0_req_val = 1'b0;
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    for (int j = 0; j < 4; j++) resp_to(8'h80 + 8'(j), j[0]);

    // Response with nothing outstanding is left unconsumed and unrouted.
    mem_resp_val = 1'b1; mem_resp_msg = mresp(3'd0, 8'hee);
    cyc(6'b000000);
    idle_inputs();
    cyc(6'b000000);
    done = 1'b1;
  end

  logic [5:0]    e_lvl, a_lvl;
  logic [RQ-1:0] e_rq;
  logic [RS-1:0] e_rs;

  always @(negedge clk) begin
    if (lvl_q.size() > 0) begin
      e_lvl = lvl_q.pop_front();
      a_lvl = {mem_req_val, c0_req_rdy, c1_req_rdy, mem_resp_rdy, c0_resp_val, c1_resp_val};
      n_vec++;
      if (a_lvl !== e_lvl) begin
        n_err++;
        $display("FAIL levels @%0t: got %b expected %b", $time, a_lvl, e_lvl);
      end
    end
    if (mem_req_val && mem_req_rdy) begin
      n_vec++;
      if (mem_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_req @%0t: got unexpected %h expected none", $time, mem_req_msg);
      end else begin
        e_rq = mem_q.pop_front();
        if (mem_req_msg !== e_rq) begin
          n_err++;
          $display("FAIL mem_req @%0t: got %h expected %h", $time, mem_req_msg, e_rq);
        end
      end
    end
    if (c0_resp_val && c0_resp_rdy) begin
      n_vec++;
      if (r0_q.size() == 0) begin
        n_err++;
        $display("FAIL resp0 @%0t: got unexpected %h expected none", $time, c0_resp_msg);
      end else begin
        e_rs = r0_q.pop_front();
        if (c0_resp_msg !== e_rs) begin
          n_err++;
          $display("FAIL resp0 @%0t: got %h expected %h", $time, c0_resp_msg, e_rs);
        end
      end
    end
    if (c1_resp_val && c1_resp_rdy) begin
      n_vec++;
      if (r1_q.size() == 0) begin
        n_err++;
        $display("FAIL resp1 @%0t: got unexpected %h expected none", $time, c1_resp_msg);
      end else begin
        e_rs = r1_q.pop_front();
        if (c1_resp_msg !== e_rs) begin
          n_err++;
          $display("FAIL resp1 @%0t: got %h expected %h", $time, c1_resp_msg, e_rs);
        end
      end
    end
    if (done) begin
      n_vec++;
      if (mem_q.size() + r0_q.size() + r1_q.size() + lvl_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover: got %0d req %0d resp0 %0d resp1 %0d lvl pending, expected 0",
                 mem_q.size(), r0_q.size(), r1_q.size(), lvl_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected done within 100000 time units");
    $fatal(1);
  end

endmodule
